sma_channel_scheduler: RTL and testbench
========================================

# sma_channel_scheduler

- Time-multiplexes one simple-moving-average datapath across `CH` independent Q8.8 sample streams.
- Each channel has a one-deep pending register with a valid/ready handshake.
- A round-robin arbiter grants one pending channel per cycle to the shared subtract/add/shift unit. The unit updates that channel's private window and running sum.
- Sits between the per-sensor front ends and downstream preprocessing. It replaces per-channel moving-average instances where area matters.

## Interface
- `CH`, default 4: number of channels, ≥2.
- `N`, default 8: window length, a power of 2, ≥2.
- `clk` input, 1 bit: the only clock. Everything is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, `CH` bits: per-channel sample offered.
- `in_data` input, `CH*16` bits: unsigned Q8.8 samples. Channel c is at bits [16c+15:16c].
- `in_ready` output, `CH` bits: per-channel ready. A sample is accepted on an edge where `in_valid[c] & in_ready[c]`.
- `chan_clear` input, `CH` bits: per-channel synchronous clear of the window.
- `out_valid` output, 1 bit: one-cycle pulse per processed sample.
- `out_ch` output, `$clog2(CH)` bits: channel of the current result.
- `out_sma` output, 16 bits: Q8.8 average.
- `out_warm` output, 1 bit: window held N real samples when this result was computed.

## Operation
- Per-channel state:
  - `window[c][0:N-1]`: 16 bits each.
  - `sum[c]`: 16+log2(N) bits. It cannot overflow.
  - `idx[c]`: log2(N) bits, wraps N-1 → 0.
  - `fill[c]`: 0..N, saturating.
  - `pend_valid[c]` and `pend_data[c]`: the pending sample.
- Handshake:
  - `in_ready[c] = !rst & (!pend_valid[c] | grant[c])`, computed combinationally.
  - On accept, `pend_data[c] <= in_data[c]` and `pend_valid[c] <= 1`.
  - Otherwise a grant clears `pend_valid[c]`.
- Arbiter:
  - Requests are `pend_valid & ~chan_clear`.
  - The grant goes to the first requesting channel at or after `rr_ptr`, searching with wrap.
  - On a grant, `rr_ptr <= grant_idx+1` (mod CH). It holds when there is no grant.
  - At most one grant per cycle.
- Compute on grant to channel g, all in one cycle:
  - `new_sum = sum[g] - window[g][idx[g]] + pend_data[g]`.
  - `window[g][idx[g]] <= pend_data[g]`, `sum[g] <= new_sum`, `idx[g] <= idx[g]+1`.
  - `fill[g] <= min(fill[g]+1, N)`.
- Output registers:
  - `out_valid <= 1`, `out_ch <= g`.
  - `out_sma <= new_sum >> log2(N)`: truncating, and it includes the new sample.
  - `out_warm <= (fill[g]+1 >= N)`.
- When no grant occurs, `out_valid <= 0`. `out_ch`, `out_sma` and `out_warm` hold their last values.
- Warm-up:
  - Empty slots read as 0, so the first N-1 results of a channel are zero-padded averages with `out_warm=0`.
- `chan_clear[c]` has priority over everything else for channel c:
  - Zeros `window[c]`, `sum[c]`, `idx[c]`, `fill[c]` and `pend_valid[c]`.
  - Channel c is excluded from arbitration in that cycle, so it produces no output.
  - `in_ready[c]` is forced to 0 that cycle, so no sample is accepted.
  - Other channels are unaffected.
- Reset:
  - All per-channel state, `rr_ptr`, and all outputs become 0: `out_valid`, `out_ch`, `out_sma`, `out_warm`.
  - `in_ready` reads 0 while `rst` is high and all-ones on the first cycle after.
  - A reset mid-stream discards pending samples. No output appears for them.

## Timing
- Accept-to-output latency is 2 edges with no contention:
  - Sample accepted at edge k.
  - Granted in the cycle after edge k.
  - `out_valid` is high for the cycle after edge k+1.
- With R channels pending, a channel waits at most R-1 extra cycles.
- Throughput:
  - One result per cycle in aggregate.
  - A lone channel sustains 1 sample/cycle, because `in_ready` stays high through grant-and-reload.
  - With all CH channels busy, each channel gets 1 sample per CH cycles.
- No combinational path from `in_valid` or `in_data` to any output. `in_ready` depends only on registered state, `rst` and `chan_clear`.

## Test plan
1. **Single channel, constant input.** N=8. After reset, stream 0x0100 on ch0 every cycle.
   - `out_sma` = 0x0020, 0x0040 … 0x0100.
   - `out_warm=0` for the first 7 results, 1 from the 8th on.
   - First `out_valid` two edges after the first accept, then back-to-back; `out_ch=0`.
2. **Window wrap.** Continue test 1 with one sample of 0x0900.
   - `out_sma` = (7·0x100 + 0x900)>>3 = 0x0200, `out_warm=1`.
   - Then 0x0100 → 0x0200 (0x900 still in the window).
3. **Fair arbitration.** Hold `in_valid=4'b1111` on all four channels.
   - `out_ch` sequence is 0, 1, 2, 3, 0, … with no gaps.
   - Each `in_ready[c]` is high exactly once per 4 cycles.
   - Every accepted sample appears exactly once.
4. **Full-scale input.** Stream 0xFFFF ×8 on ch2.
   - 8th result: `sum`=0x7FFF8, `out_sma`=0xFFFF, no wrap.
   - Then 0x0000 ×8 decays to 0x0000.
5. **Clear mid-stream.** Warm ch1. Pulse `chan_clear[1]` while ch1 is pending and ch3 is streaming.
   - No ch1 output that cycle and its pending sample is dropped.
   - Next ch1 sample 0x0800 → `out_sma`=0x0100, `out_warm=0`.
   - ch3 results are unchanged.
6. **Reset mid-stream.** Assert `rst` for 1 cycle during test 3.
   - The next cycle has `out_valid=0`, `in_ready=0` and all outputs zero.
   - After release, the first grant goes to ch0 and averages restart from zero-padded windows.

Source files
------------

// File: rtl/sma_channel_scheduler.sv
// Shared simple-moving-average engine time-multiplexed across CH Q8.8 streams.
// Each channel owns a one-deep pending slot; a round-robin arbiter feeds one per cycle.
module sma_channel_scheduler #(
  parameter int unsigned CH = 4,
  parameter int unsigned N  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         in_valid,
  input  logic [CH*16-1:0]      in_data,
  output logic [CH-1:0]         in_ready,
  input  logic [CH-1:0]         chan_clear,
  output logic                  out_valid,
  output logic [$clog2(CH)-1:0] out_ch,
  output logic [15:0]           out_sma,
  output logic                  out_warm
);

  localparam int unsigned CW = $clog2(CH);
  localparam int unsigned NW = $clog2(N);
  localparam int unsigned SW = 16 + NW;
  localparam int unsigned FW = NW + 1;

  logic [15:0]    window_q [CH][N];
  logic [15:0]    window_d [CH][N];
  logic [SW-1:0]  sum_q [CH];
  logic [SW-1:0]  sum_d [CH];
  logic [NW-1:0]  idx_q [CH];
  logic [NW-1:0]  idx_d [CH];
  logic [FW-1:0]  fill_q [CH];
  logic [FW-1:0]  fill_d [CH];
  logic [15:0]    pend_data_q [CH];
  logic [15:0]    pend_data_d [CH];
  logic [CH-1:0]  pend_valid_q, pend_valid_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;

  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [15:0]    out_sma_q, out_sma_d;
  logic           out_warm_q, out_warm_d;

  logic [CH-1:0]  req;
  logic [CH-1:0]  grant_vec;
  logic           grant_any;
  logic [CW-1:0]  grant_idx;
  int unsigned    pos;
  logic [SW-1:0]  new_sum;

  // Round-robin search starting at rr_ptr, wrapping at CH.
  always_comb begin
    req       = pend_valid_q & ~chan_clear;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    pos       = 0;
    for (int unsigned i = 0; i < CH; i++) begin
      pos = 32'(rr_ptr_q) + i;
      if (pos >= CH) pos = pos - CH;
      if (!grant_any && req[CW'(pos)]) begin
        grant_any = 1'b1;
        grant_idx = CW'(pos);
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  // A granted slot frees itself in the same cycle, so a lone channel streams at full rate.
  assign in_ready = rst ? '0 : ((~pend_valid_q | grant_vec) & ~chan_clear);

  assign new_sum = sum_q[grant_idx]
                 - SW'(window_q[grant_idx][idx_q[grant_idx]])
                 + SW'(pend_data_q[grant_idx]);

  always_comb begin
    window_d     = window_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = grant_any;
    out_ch_d     = out_ch_q;
    out_sma_d    = out_sma_q;
    out_warm_d   = out_warm_q;

    for (int unsigned c = 0; c < CH; c++) begin
      if (chan_clear[c]) begin
        for (int unsigned j = 0; j < N; j++) window_d[c][j] = '0;
        sum_d[c]        = '0;
        idx_d[c]        = '0;
        fill_d[c]       = '0;
        pend_valid_d[c] = 1'b0;
      end else begin
        if (grant_vec[c]) begin
          window_d[c][idx_q[c]] = pend_data_q[c];
          sum_d[c]              = new_sum;
          idx_d[c]              = idx_q[c] + NW'(1);
          fill_d[c]             = (fill_q[c] == FW'(N)) ? fill_q[c] : fill_q[c] + FW'(1);
          pend_valid_d[c]       = 1'b0;
        end
        if (in_valid[c] && in_ready[c]) begin
          pend_valid_d[c] = 1'b1;
          pend_data_d[c]  = in_data[16*c +: 16];
        end
      end
    end

    if (grant_any) begin
      rr_ptr_d   = (grant_idx == CW'(CH-1)) ? '0 : grant_idx + CW'(1);
      out_ch_d   = grant_idx;
      out_sma_d  = new_sum[NW +: 16];
      out_warm_d = (fill_q[grant_idx] >= FW'(N-1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < CH; c++) begin
        for (int unsigned j = 0; j < N; j++) window_q[c][j] <= '0;
        sum_q[c]       <= '0;
        idx_q[c]       <= '0;
        fill_q[c]      <= '0;
        pend_data_q[c] <= '0;
      end
      pend_valid_q <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sma_q    <= '0;
      out_warm_q   <= 1'b0;
    end else begin
      window_q     <= window_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sma_q    <= out_sma_d;
      out_warm_q   <= out_warm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_sma   = out_sma_q;
  assign out_warm  = out_warm_q;

endmodule

// File: tb/tb_sma_channel_scheduler.sv
// Directed bench for sma_channel_scheduler with hand-computed expected averages.
module tb_sma_channel_scheduler;

  localparam int unsigned CH = 4;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in_valid;
  logic [CH*16-1:0] in_data;
  logic [CH-1:0] in_ready;
  logic [CH-1:0] chan_clear;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [15:0]   out_sma;
  logic          out_warm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sma_channel_scheduler #(.CH(CH), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .chan_clear (chan_clear),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_sma    (out_sma),
    .out_warm   (out_warm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; chan_clear = '0; in_data = '0;
    step(); step();
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected %h", in_ready, 4'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
    checks++; if (out_sma !== 16'h0) begin errors++; $display("FAIL reset_sma: got %h expected 0000", out_sma); end
    checks++; if (out_warm !== 1'b0) begin errors++; $display("FAIL reset_warm: got %b expected 0", out_warm); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL post_reset_ready: got %h expected f", in_ready); end
  endtask

  // Constant 0x0100 on ch0, then one 0x0900 wrap sample.
  task automatic test_single_and_wrap();
    logic [15:0] stim [11];
    logic [15:0] exp_s [11];
    stim  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              16'h0100, 16'h0900, 16'h0100};
    exp_s = '{16'h0020, 16'h0040, 16'h0060, 16'h0080, 16'h00A0, 16'h00C0, 16'h00E0, 16'h0100,
              16'h0100, 16'h0200, 16'h0200};
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) begin
        in_valid = 4'b0001;
        in_data  = {48'h0, stim[i]};
        #1;
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready[%0d]: got %b expected 1", i, in_ready[0]); end
      end else begin
        in_valid = '0;
      end
      step();
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, out_valid); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL single_ch[%0d]: got %0d expected 0", i, out_ch); end
        checks++; if (out_sma !== exp_s[i-1]) begin errors++; $display("FAIL single_sma[%0d]: got %h expected %h", i, out_sma, exp_s[i-1]); end
        checks++; if (out_warm !== (i >= 8)) begin errors++; $display("FAIL single_warm[%0d]: got %b expected %b", i, out_warm, (i >= 8)); end
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  // Full-scale fill then decay on ch2.
  task automatic test_full_scale();
    logic [15:0] exp_s [16];
    exp_s = '{16'h1FFF, 16'h3FFF, 16'h5FFF, 16'h7FFF, 16'h9FFF, 16'hBFFF, 16'hDFFF, 16'hFFFF,
              16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h7FFF, 16'h5FFF, 16'h3FFF, 16'h1FFF, 16'h0000};
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        in_valid = 4'b0100;
        in_data  = {16'h0, (i < 8) ? 16'hFFFF : 16'h0000, 32'h0};
      end else begin
        in_valid = '0;
      end
      step();
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin errors++; $display("FAIL full_valid_ch[%0d]: got %b/%0d expected 1/2", i, out_valid, out_ch); end
        checks++; if (out_sma !== exp_s[i-1]) begin errors++; $display("FAIL full_sma[%0d]: got %h expected %h", i, out_sma, exp_s[i-1]); end
        checks++; if (out_warm !== (i >= 8)) begin errors++; $display("FAIL full_warm[%0d]: got %b expected %b", i, out_warm, (i >= 8)); end
      end
    end
    step();
  endtask

  // All four channels valid: strict rotation with one ready per cycle.
  task automatic test_fair();
    in_data  = {16'h2000, 16'h1800, 16'h1000, 16'h0800};
    in_valid = 4'hF;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL fair_rst_ready: got %h expected 0", in_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL fair_start_ready: got %h expected f", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fair_first: got %b expected 0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  exp_r;
      logic [15:0] exp_s;
      exp_r = 4'(1 << (i % 4));
      exp_s = 16'((i % 4 + 1) * (i / 4 + 1) * 16'h0100);
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", i, in_ready, exp_r); end
      step();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(i % 4)) begin errors++; $display("FAIL fair_ch[%0d]: got %b/%0d expected 1/%0d", i, out_valid, out_ch, i % 4); end
      checks++; if (out_sma !== exp_s) begin errors++; $display("FAIL fair_sma[%0d]: got %h expected %h", i, out_sma, exp_s); end
    end
  endtask

  // Reset while all channels are streaming; pending samples vanish.
  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_ready: got %h expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_sma !== 16'h0 || out_warm !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: got %b/%0d/%h/%b expected 0/0/0000/0", out_valid, out_ch, out_sma, out_warm);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL mid_release_ready: got %h expected f", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_sma !== 16'h0100 || out_warm !== 1'b0) begin
      errors++; $display("FAIL mid_first: got %b/%0d/%h/%b expected 1/0/0100/0", out_valid, out_ch, out_sma, out_warm);
    end
    step();
    checks++; if (out_ch !== 2'd1 || out_sma !== 16'h0200) begin errors++; $display("FAIL mid_second: got %0d/%h expected 1/0200", out_ch, out_sma); end
    in_valid = '0;
    step(); step(); step(); step(); step();
  endtask

  // Clear ch1 while it is pending and ch3 streams.
  task automatic test_clear();
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8) ? 4'b0010 : 4'b0000;
      in_data  = {32'h0, 16'h0800, 16'h0};
      step();
      if (i > 0) begin
        checks++; if (out_ch !== 2'd1 || out_sma !== 16'(i * 16'h0100)) begin errors++; $display("FAIL warm_sma[%0d]: got %0d/%h expected 1/%h", i, out_ch, out_sma, 16'(i * 16'h0100)); end
      end
    end
    checks++; if (out_warm !== 1'b1) begin errors++; $display("FAIL warm_flag: got %b expected 1", out_warm); end
    in_valid = 4'b1010;
    in_data  = {16'h0800, 16'h0, 16'h0400, 16'h0};
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b expected 0", out_valid); end
    chan_clear = 4'b0010;
    in_data    = {16'h0800, 16'h0, 16'h0800, 16'h0};
    #1;
    checks++; if (in_ready !== 4'b1101) begin errors++; $display("FAIL clr_ready: got %b expected 1101", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_sma !== 16'h0100 || out_warm !== 1'b0) begin
      errors++; $display("FAIL clr_ch3_a: got %b/%0d/%h/%b expected 1/3/0100/0", out_valid, out_ch, out_sma, out_warm);
    end
    chan_clear = '0;
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL clr_after_ready: got %b expected 1111", in_ready); end
    step();
    checks++; if (out_ch !== 2'd3 || out_sma !== 16'h0200) begin errors++; $display("FAIL clr_ch3_b: got %0d/%h expected 3/0200", out_ch, out_sma); end
    in_valid = 4'b1000;
    #1;
    checks++; if (in_ready !== 4'b0111) begin errors++; $display("FAIL clr_busy_ready: got %b expected 0111", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_sma !== 16'h0100 || out_warm !== 1'b0) begin
      errors++; $display("FAIL clr_ch1: got %b/%0d/%h/%b expected 1/1/0100/0", out_valid, out_ch, out_sma, out_warm);
    end
    in_valid = '0;
    step();
    checks++; if (out_ch !== 2'd3 || out_sma !== 16'h0300) begin errors++; $display("FAIL clr_ch3_c: got %0d/%h expected 3/0300", out_ch, out_sma); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_drain: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_and_wrap();
    test_full_scale();
    test_fair();
    test_reset_mid();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
